// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI execute-in-place fetch front-end.
// Register map, status codes, CCR layout and fetch FSM states.
package qspi_pkg;

  localparam logic [5:0] QSPI_CCR = 6'd0;
  localparam logic [5:0] QSPI_ADR = 6'd4;
  localparam logic [5:0] QSPI_DR  = 6'd8;
  localparam logic [5:0] QSPI_STA = 6'd40;

  localparam logic [31:0] STA_IDLE = 32'd1;
  localparam logic [31:0] STA_CMD  = 32'd2;

  localparam int LINE_WORDS = 8;
  localparam int TAG_W      = 19;

  localparam int CCR_START     = 31;
  localparam int CCR_PRESC_LSB = 25;
  localparam int CCR_SIZE_LSB  = 16;
  localparam int CCR_DUMMY_LSB = 11;
  localparam int CCR_DIR       = 10;
  localparam int CCR_MODE_LSB  = 8;
  localparam int CCR_CMD_LSB   = 0;

  typedef enum logic [3:0] {
    S_SYNC,
    S_IDLE,
    S_WR_ADR,
    S_WR_CCR,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_FILL,
    S_RESP,
    S_ERR
  } fetch_state_e;

  function automatic logic [31:0] ccr_word(
    input logic [5:0] presc,
    input logic [4:0] dummy,
    input logic [1:0] mode,
    input logic [7:0] cmd
  );
    logic [31:0] w;
    w = '0;
    w[CCR_START] = 1'b1;
    w[CCR_PRESC_LSB +: 6] = presc;
    w[CCR_SIZE_LSB +: 5] = 5'd31;
    w[CCR_DUMMY_LSB +: 5] = dummy;
    w[CCR_DIR] = 1'b0;
    w[CCR_MODE_LSB +: 2] = mode;
    w[CCR_CMD_LSB +: 8] = cmd;
    return w;
  endfunction

endpackage

// File: rtl/qspi_xip_fetch_if.sv
// Fetch request/response and QSPI register-port signals.
// slave: the fetch engine; master: the surrounding system.
interface qspi_xip_fetch_if;
  logic        req_i;
  logic [23:0] addr_i;
  logic        flush_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        qspi_write_o;
  logic [3:0]  qspi_be_o;
  logic [5:0]  qspi_addr_o;
  logic [31:0] qspi_wdata_o;
  logic [31:0] qspi_rdata_i;

  modport slave (
    input  req_i, addr_i, flush_i, qspi_rdata_i,
    output ready_o, rvalid_o, rdata_o, err_o,
    output qspi_write_o, qspi_be_o, qspi_addr_o, qspi_wdata_o
  );

  modport master (
    output req_i, addr_i, flush_i, qspi_rdata_i,
    input  ready_o, rvalid_o, rdata_o, err_o,
    input  qspi_write_o, qspi_be_o, qspi_addr_o, qspi_wdata_o
  );
endinterface

// File: rtl/qspi_line_buf.sv
// One 32-byte line: 8 data words plus tag and valid.
// Clearing valid wins over setting it in the same cycle.
module qspi_line_buf
  import qspi_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_we,
  input  logic [2:0]       i_widx,
  input  logic [31:0]      i_wdata,
  input  logic             i_tag_we,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_set_valid,
  input  logic             i_clr_valid,
  input  logic [2:0]       i_ridx,
  output logic [31:0]      o_rdata,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_valid
);

  logic [31:0]      r_data [LINE_WORDS];
  logic [TAG_W-1:0] r_tag;
  logic             r_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        r_data[i] <= '0;
      end
      r_tag   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_we) begin
        r_data[i_widx] <= i_wdata;
      end
      if (i_tag_we) begin
        r_tag <= i_tag;
      end
      if (i_clr_valid) begin
        r_valid <= 1'b0;
      end else if (i_set_valid) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign o_rdata = r_data[i_ridx];
  assign o_tag   = r_tag;
  assign o_valid = r_valid;

endmodule

// File: rtl/qspi_xip_fetch.sv
// XIP fetch engine: serves word reads from a one-line buffer and
// refills it through the QSPI master's ADR/CCR/STA/DR registers.
module qspi_xip_fetch
  import qspi_pkg::*;
#(
  parameter logic [5:0]  PRESCALER   = 6'd2,
  parameter logic [1:0]  DATA_MODE   = 2'd3,
  parameter logic [4:0]  DUMMY_FIELD = 5'd4,
  parameter logic [7:0]  RD_CMD      = 8'h6B,
  parameter int          RD_LAT      = 1,
  parameter logic [15:0] TIMEOUT     = 16'd4096
) (
  input logic             clk_i,
  input logic             rst_ni,
  qspi_xip_fetch_if.slave bus
);

  localparam logic [31:0] CCR_VAL =
    ccr_word(PRESCALER, DUMMY_FIELD, DATA_MODE, RD_CMD);
  localparam logic [1:0]  LAT      = 2'(RD_LAT);
  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

  fetch_state_e r_state, w_next;

  logic [1:0]       r_ph, w_ph;
  logic [2:0]       r_word, w_word;
  logic [15:0]      r_cnt, w_cnt;
  logic             r_flushed, w_flushed;
  logic             r_rvalid, w_rvalid;
  logic [31:0]      r_rdata, w_rdata;
  logic             r_err, w_err;
  logic             w_buf_we, w_tag_we;
  logic             w_set_valid, w_clr_valid;
  logic [31:0]      w_buf_rdata;
  logic [TAG_W-1:0] w_tag;
  logic             w_valid, w_hit;
  logic             w_sample, w_tmo;
  logic [31:0]      w_want;
  logic             w_ready, w_write;
  logic [3:0]       w_be;
  logic [5:0]       w_addr;
  logic [31:0]      w_wdata;
  logic             w_unused;

  assign w_unused = ^bus.addr_i[1:0];
  assign w_sample = (r_ph == LAT);
  assign w_tmo    = (r_cnt == TMO_LAST);
  assign w_hit    = w_valid && !bus.flush_i &&
                    (w_tag == bus.addr_i[23:5]);
  assign w_want   = (r_state == S_WAIT_BUSY) ? STA_CMD : STA_IDLE;

  qspi_line_buf u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_we        (w_buf_we),
    .i_widx      (r_word),
    .i_wdata     (bus.qspi_rdata_i),
    .i_tag_we    (w_tag_we),
    .i_tag       (bus.addr_i[23:5]),
    .i_set_valid (w_set_valid),
    .i_clr_valid (w_clr_valid),
    .i_ridx      (bus.addr_i[4:2]),
    .o_rdata     (w_buf_rdata),
    .o_tag       (w_tag),
    .o_valid     (w_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ph      <= '0;
      r_word    <= '0;
      r_cnt     <= '0;
      r_flushed <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_ph      <= w_ph;
      r_word    <= w_word;
      r_cnt     <= w_cnt;
      r_flushed <= w_flushed;
      r_rvalid  <= w_rvalid;
      r_rdata   <= w_rdata;
      r_err     <= w_err;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ph        = '0;
    w_word      = r_word;
    w_cnt       = '0;
    w_flushed   = r_flushed | bus.flush_i;
    w_rvalid    = 1'b0;
    w_rdata     = r_rdata;
    w_err       = 1'b0;
    w_buf_we    = 1'b0;
    w_tag_we    = 1'b0;
    w_set_valid = 1'b0;
    w_clr_valid = bus.flush_i;
    w_ready     = 1'b0;
    w_write     = 1'b0;
    w_be        = '0;
    w_addr      = QSPI_STA;
    w_wdata     = '0;
    unique case (r_state)
      S_SYNC, S_WAIT_BUSY, S_WAIT_DONE: begin
        w_ph   = w_sample ? 2'd0 : r_ph + 2'd1;
        w_cnt  = r_cnt + 16'd1;
        w_word = '0;
        if (w_sample && bus.qspi_rdata_i == w_want) begin
          w_cnt  = '0;
          w_next = (r_state == S_SYNC)      ? S_IDLE :
                   (r_state == S_WAIT_BUSY) ? S_WAIT_DONE :
                                              S_FILL;
        end else if (w_tmo) begin
          // Idle-time expiry in SYNC has no requester to notify.
          w_cnt = '0;
          w_ph  = '0;
          if (r_state != S_SYNC) begin
            w_clr_valid = 1'b1;
            w_next      = S_ERR;
          end
        end
      end
      S_IDLE: begin
        if (bus.req_i && !r_rvalid) begin
          w_ready = 1'b1;
          if (w_hit) begin
            w_next = S_RESP;
          end else begin
            w_tag_we    = 1'b1;
            w_clr_valid = 1'b1;
            w_flushed   = 1'b0;
            w_next      = S_WR_ADR;
          end
        end
      end
      S_WR_ADR: begin
        w_write = 1'b1;
        w_be    = 4'hF;
        w_addr  = QSPI_ADR;
        w_wdata = {8'h00, w_tag, 5'b0};
        w_next  = S_WR_CCR;
      end
      S_WR_CCR: begin
        w_write = 1'b1;
        w_be    = 4'hF;
        w_addr  = QSPI_CCR;
        w_wdata = CCR_VAL;
        w_next  = S_WAIT_BUSY;
      end
      S_FILL: begin
        w_addr = QSPI_DR + {1'b0, r_word, 2'b00};
        w_ph   = w_sample ? 2'd0 : r_ph + 2'd1;
        if (w_sample) begin
          w_buf_we = 1'b1;
          w_word   = r_word + 3'd1;
          if (r_word == 3'd7) begin
            w_set_valid = !(r_flushed || bus.flush_i);
            w_next      = S_RESP;
          end
        end
      end
      S_RESP: begin
        w_rvalid = 1'b1;
        w_rdata  = w_buf_rdata;
        w_next   = S_IDLE;
      end
      S_ERR: begin
        w_rvalid = 1'b1;
        w_rdata  = '0;
        w_err    = 1'b1;
        w_next   = S_SYNC;
      end
      default: begin
        w_next = S_SYNC;
      end
    endcase
  end

  assign bus.ready_o      = w_ready;
  assign bus.rvalid_o     = r_rvalid;
  assign bus.rdata_o      = r_rdata;
  assign bus.err_o        = r_err;
  assign bus.qspi_write_o = w_write;
  assign bus.qspi_be_o    = w_be;
  assign bus.qspi_addr_o  = w_addr;
  assign bus.qspi_wdata_o = w_wdata;

endmodule

// File: tb/tb_qspi_xip_fetch.sv
// Bench for qspi_xip_fetch: QSPI register-port slave model, line-level
// hit/miss model, and a per-cycle bus/response checker.
module tb_qspi_xip_fetch;
  import qspi_pkg::*;

  localparam logic [31:0] CCR_EXP =
    {1'b1, 6'd2, 4'd0, 5'd31, 5'd4, 1'b0, 2'd3, 8'h6B};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qspi_xip_fetch_if bus ();

  qspi_xip_fetch u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] flash_word(input logic [21:0] wa);
    logic [31:0] w;
    w = {10'd0, wa};
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [2:0] dr_idx(input logic [5:0] a);
    logic [5:0] o;
    o = a - 6'd8;
    return o[4:2];
  endfunction

  // slave model: flash behind ADR/CCR/STA/DR, one-cycle read latency
  logic [18:0] adr_tag = '0;
  int  busy_cnt = 0;
  bit  hold_cmd = 1'b0;
  bit  force_busy = 1'b0;

  always @(posedge clk) begin
    if (bus.qspi_write_o && bus.qspi_addr_o == QSPI_ADR)
      adr_tag <= bus.qspi_wdata_o[23:5];
    if (bus.qspi_write_o && bus.qspi_addr_o == QSPI_CCR)
      busy_cnt <= int'($urandom_range(12, 4));
    else if (busy_cnt > 0)
      busy_cnt <= busy_cnt - 1;
    if (bus.qspi_addr_o >= QSPI_DR && bus.qspi_addr_o < QSPI_STA)
      bus.qspi_rdata_i <= flash_word({adr_tag, dr_idx(bus.qspi_addr_o)});
    else if (bus.qspi_addr_o == QSPI_STA)
      bus.qspi_rdata_i <= force_busy ? 32'd3 :
                          hold_cmd   ? 32'd2 :
                          (busy_cnt > 0) ? 32'd2 : 32'd1;
    else
      bus.qspi_rdata_i <= 32'hDEADBEEF;
  end

  // line model and expectations for the current request
  bit          m_valid = 1'b0;
  logic [18:0] m_tag = '0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_adr = '0;
  logic [31:0] last_adr = '0;
  logic [31:0] last_ccr = '0;
  int nwr = 0, ndr = 0, nrv = 0;
  logic       prev_wr = 1'b0;
  logic [5:0] prev_off = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.qspi_write_o) begin
        nwr++;
        chk("wr_be", 32'(bus.qspi_be_o), 32'hF);
        if (bus.qspi_addr_o == QSPI_ADR) begin
          last_adr = bus.qspi_wdata_o;
          chk("adr_wdata", bus.qspi_wdata_o, exp_adr);
        end else if (bus.qspi_addr_o == QSPI_CCR) begin
          last_ccr = bus.qspi_wdata_o;
          chk("ccr_wdata", bus.qspi_wdata_o, CCR_EXP);
        end else begin
          chk("wr_offset", 32'(bus.qspi_addr_o), 32'(QSPI_ADR));
        end
        if (prev_wr)
          chk("wr_same_off", 32'(bus.qspi_addr_o != prev_off), 32'd1);
      end
      if (bus.qspi_addr_o >= QSPI_DR && bus.qspi_addr_o < QSPI_STA)
        ndr++;
      if (bus.rvalid_o) begin
        nrv++;
        chk("rdata", bus.rdata_o, exp_rdata);
        chk("err", 32'(bus.err_o), 32'(exp_err));
      end
      prev_wr  = bus.qspi_write_o;
      prev_off = bus.qspi_addr_o;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_ready"}, 32'(bus.ready_o), 32'd0);
    chk({p, "_rvalid"}, 32'(bus.rvalid_o), 32'd0);
    chk({p, "_rdata"}, bus.rdata_o, 32'd0);
    chk({p, "_err"}, 32'(bus.err_o), 32'd0);
    chk({p, "_write"}, 32'(bus.qspi_write_o), 32'd0);
    chk({p, "_be"}, 32'(bus.qspi_be_o), 32'd0);
    chk({p, "_addr"}, 32'(bus.qspi_addr_o), 32'd40);
    chk({p, "_wdata"}, bus.qspi_wdata_o, 32'd0);
  endtask

  task automatic set_exp(input logic [23:0] a);
    exp_err   = hold_cmd;
    exp_rdata = hold_cmd ? 32'd0 : flash_word(a[23:2]);
    exp_adr   = {8'h00, a[23:5], 5'b0};
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_req(input logic [23:0] a, input bit mid_flush,
                        input bit fl_req, input int limit,
                        output int lat);
    bit hit, got, fl_done;
    int n, rdy_at;
    hit = m_valid && (m_tag == a[23:5]) && !fl_req;
    set_exp(a);
    got = 1'b0;
    fl_done = 1'b0;
    @(negedge clk);
    nwr = 0; ndr = 0; nrv = 0;
    bus.req_i = 1'b1;
    bus.addr_i = a;
    bus.flush_i = fl_req;
    #1;
    rdy_at = bus.ready_o ? 0 : -1;
    n = 0;
    while (n < limit && !got) begin
      @(negedge clk);
      n++;
      bus.flush_i = 1'b0;
      if (mid_flush && !fl_done && bus.qspi_addr_o == 6'd20) begin
        bus.flush_i = 1'b1;
        fl_done = 1'b1;
      end
      if (rdy_at < 0 && bus.ready_o) rdy_at = n;
      if (bus.rvalid_o) got = 1'b1;
    end
    bus.req_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    lat = n;
    chk("rsp_seen", 32'(got), 32'd1);
    chk("one_rsp", 32'(nrv), 32'd1);
    if (hit) begin
      chk("hit_ready", 32'(rdy_at), 32'd0);
      chk("hit_lat", 32'(n), 32'd2);
      chk("hit_nwr", 32'(nwr), 32'd0);
      chk("hit_ndr", 32'(ndr), 32'd0);
    end else begin
      chk("miss_ready", 32'(rdy_at >= 0), 32'd1);
      chk("miss_nwr", 32'(nwr), 32'd2);
      chk("miss_ndr", 32'(ndr), hold_cmd ? 32'd0 : 32'd16);
    end
    if (hold_cmd) begin
      m_valid = 1'b0;
    end else if (!hit) begin
      m_tag = a[23:5];
      m_valid = !(mid_flush || fl_req);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, n;
    logic [18:0] pool [4];
    logic [23:0] a;
    bus.req_i = 1'b0;
    bus.addr_i = '0;
    bus.flush_i = 1'b0;
    bus.qspi_rdata_i = '0;
    #2;
    chk_reset("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_req(24'h000124, 1'b0, 1'b0, 300, lat);
    chk("cold_adr", last_adr, 32'h00000120);
    chk("cold_ccr", last_ccr, 32'h841F236B);
    chk("cold_word1", exp_rdata, flash_word(22'h000049));
    do_req(24'h00013C, 1'b0, 1'b0, 300, lat);
    chk("hit_lat_lit", 32'(lat), 32'd2);

    pulse_flush();
    do_req(24'h000120, 1'b0, 1'b0, 300, lat);
    do_req(24'h000128, 1'b0, 1'b0, 300, lat);
    pulse_flush();
    do_req(24'h000128, 1'b1, 1'b0, 300, lat);
    do_req(24'h00012C, 1'b0, 1'b0, 300, lat);
    do_req(24'h000130, 1'b0, 1'b1, 300, lat);
    pulse_flush();

    do_req(24'hFFFFFC, 1'b0, 1'b0, 300, lat);
    chk("top_adr", last_adr, 32'h00FFFFE0);
    do_req(24'hFFFFE0, 1'b0, 1'b0, 300, lat);

    pool[0] = 19'h00009;
    pool[1] = 19'($urandom);
    pool[2] = 19'($urandom);
    pool[3] = 19'h7FFFF;
    for (int i = 0; i < 40; i++) begin
      a = {pool[$urandom_range(3, 0)], 3'($urandom), 2'($urandom)};
      if ($urandom_range(5, 0) == 0) pulse_flush();
      do_req(a, ($urandom_range(7, 0) == 0), 1'b0, 300, lat);
    end

    hold_cmd = 1'b1;
    do_req(24'h000400, 1'b0, 1'b0, 6000, lat);
    chk("tmo_lat", 32'(lat >= 4096 && lat <= 4200), 32'd1);
    hold_cmd = 1'b0;
    do_req(24'h000404, 1'b0, 1'b0, 300, lat);
    do_req(24'h000408, 1'b0, 1'b0, 300, lat);

    set_exp(24'h000200);
    @(negedge clk);
    bus.req_i = 1'b1;
    bus.addr_i = 24'h000200;
    n = 0;
    while (n < 300 && bus.qspi_addr_o != 6'd20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_at_w3", 32'(bus.qspi_addr_o), 32'd20);
    force_busy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset("midfill");
    bus.req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nwr = 0;
    repeat (30) @(negedge clk);
    chk("busy_nwr", 32'(nwr), 32'd0);
    force_busy = 1'b0;
    m_valid = 1'b0;
    do_req(24'h000204, 1'b0, 1'b0, 300, lat);
    do_req(24'h000208, 1'b0, 1'b0, 300, lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
